uart_tx_buf: RTL and testbench
==============================

# uart_tx_buf

Buffered 8N1 UART transmitter that generates the serial frames consumed by `UART_RX`. Its `TX` output is wired directly to the receiver's `RX` input.

- A host writes bytes into a small internal FIFO.
- The block serialises each byte as start bit, 8 data bits LSB-first, then stop bit, with no idle gap between queued bytes.
- It also serves as the loopback stimulus source for receiver verification.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 1: `sck` cycles per serial bit. Legal range 1..65535.
- `DEPTH`, default 4: FIFO depth in bytes. Must be a power of 2, at least 2.

Ports:
- `sck`, input, 1 bit: clock. All logic is on the rising edge.
- `rst`, input, 1 bit: reset, synchronous, active-high.
- `data_in`, input, 8 bits: byte to queue.
- `wr_en`, input, 1 bit: write strobe, sampled on the rising edge of `sck`.
- `full`, output, 1 bit: FIFO holds `DEPTH` bytes.
- `empty`, output, 1 bit: FIFO holds 0 bytes.
- `level`, output, $clog2(DEPTH)+1 bits: current FIFO occupancy.
- `busy`, output, 1 bit: a frame is in progress (state is not IDLE).
- `TX`, output, 1 bit: serial line. Registered, idles high.

## Operation
FIFO:
- Circular buffer with read/write pointers of $clog2(DEPTH) bits that wrap modulo `DEPTH`, plus an occupancy counter.
- Write acceptance: a write is accepted iff `wr_en`=1 and `full`=0 at the edge.
- Write to a full FIFO: dropped. The stored contents and `level` are unchanged, even if a pop occurs on the same edge.
- Push and pop on the same edge: `level` is unchanged and both pointers advance.

Transmitter state machine:
- IDLE: `TX`=1. If `empty`=0, pop the head byte into the shift register and go to START.
- START: `TX`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
- DATA: drive shift register bit 0 onto `TX` for `CLKS_PER_BIT` cycles, then shift right. After 8 bits, go to PARITY (if enabled) or STOP.
- PARITY: only present when the macro below is defined. Drives the parity bit for `CLKS_PER_BIT` cycles, then goes to STOP.
- STOP: `TX`=1 for `CLKS_PER_BIT` cycles. On the final stop cycle:
  - if `empty`=0, pop the next byte and go directly to START (back-to-back frames);
  - otherwise go to IDLE.

Counters:
- The bit-time counter is 16 bits and reloads on every bit boundary.
- The bit index is 3 bits.

Data integrity:
- Bytes are transmitted in write order.
- The byte being shifted is never affected by later writes.

## Timing
Reset (`rst`=1 at an edge):
- After the edge: `TX`=1, `busy`=0, `empty`=1, `full`=0, `level`=0, state=IDLE, pointers=0.
- Reset mid-frame aborts the frame immediately and discards all queued bytes.

Latency:
- A write accepted at edge k into an empty FIFO while IDLE appears as `level`=1 after edge k.
- The pop occurs at edge k+1, after which `TX`=0 and `busy`=1.

Frame length:
- 10 × `CLKS_PER_BIT` cycles without parity.
- 11 × `CLKS_PER_BIT` cycles with parity.

Flags:
- `busy` falls at the edge that enters IDLE.
- `full`, `empty` and `level` are registered and update on the edge of the push or pop.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - The PARITY state is compiled in.
  - The parity bit is even parity: the XOR of the 8 data bits, placed between bit 7 and the stop bit.
- `UART_TX_PARITY_EN` undefined:
  - No PARITY state and no parity logic.
  - Frames are exactly 8N1.

## Test plan
All scenarios use `CLKS_PER_BIT`=1, `DEPTH`=4, and the macro undefined unless stated.

1. Reset: hold `rst`=1 for 3 cycles with `wr_en`=1 → `TX`=1, `level`=0, `empty`=1, `busy`=0 throughout; no bytes queued.
2. Single byte: write 0x6B → starting the cycle after the write, `TX` = 0,1,1,0,1,0,1,1,0,1. `busy` is high for exactly 10 cycles, then `TX`=1 and `busy`=0.
3. Back-to-back bytes: write 0x6B then 0xA9 on consecutive cycles → 20 contiguous bit times. The second frame is 0,1,0,0,1,0,1,0,1,1. No idle cycle between the first stop bit and the second start bit. Loopback into `UART_RX` yields `data_out`=0x6B, then 0xA9.
4. Overflow: while a frame is in progress, write 0x01..0x05 on 5 consecutive cycles → `full`=1 after the 4th accepted write and 0x05 is dropped. Transmitted order is the current byte, then 0x01, 0x02, 0x03, 0x04.
5. Reset mid-frame: assert `rst` during data bit 3 of 0x6B with 2 bytes queued → `TX`=1 and `level`=0 the next cycle. A subsequent write of 0xA9 transmits cleanly.
6. With `UART_TX_PARITY_EN` defined: write 0x6B, then separately 0xA9 → each frame is 11 bits, with parity bit 1 for 0x6B and 0 for 0xA9.

Source files
------------

// File: rtl/uart_tx_buf.sv
// Buffered 8N1 UART transmitter: small circular FIFO feeding a start/data/stop serialiser.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data bit 7 and the stop bit.
module uart_tx_buf #(
  parameter int CLKS_PER_BIT = 1,
  parameter int DEPTH        = 4
) (
  input  logic                     sck,
  input  logic                     rst,
  input  logic [7:0]               data_in,
  input  logic                     wr_en,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     busy,
  output logic                     TX,
  output logic [2:0]               state_dbg
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);
  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t         state, state_next;
  logic [7:0]     mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    count;
  logic [15:0]    bit_cnt, bit_cnt_next;
  logic [2:0]     bit_idx, bit_idx_next;
  logic [7:0]     shreg, shreg_next;
  logic           tx_q, tx_next;
  logic           push, pop, bit_end;
`ifdef UART_TX_PARITY_EN
  logic           par_q, par_next;
`endif

  // Write handshake: wr_en is the valid, !full is the ready; a byte is taken
  // on an edge iff wr_en && !full. A full FIFO drops the write even if a pop
  // frees a slot on that same edge.
  assign push    = wr_en && !full;
  assign full    = (count == FULL_LVL);
  assign empty   = (count == '0);
  assign level   = count;
  assign busy    = (state != IDLE);
  assign TX      = tx_q;
  assign bit_end = (bit_cnt == BIT_LAST);
  assign state_dbg = state;

  always_comb begin
    state_next   = state;
    bit_cnt_next = bit_end ? 16'd0 : bit_cnt + 16'd1;
    bit_idx_next = bit_idx;
    shreg_next   = shreg;
    tx_next      = tx_q;
    pop          = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_next     = par_q;
`endif
    case (state)
      IDLE: begin
        bit_cnt_next = 16'd0;
        tx_next      = 1'b1;
        if (!empty) begin
          pop        = 1'b1;
          state_next = START;
          tx_next    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_next = DATA;
          tx_next    = shreg[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          shreg_next = {1'b0, shreg[7:1]};
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_next = PARITY;
            tx_next    = par_q;
`else
            state_next = STOP;
            tx_next    = 1'b1;
`endif
          end else begin
            bit_idx_next = bit_idx + 3'd1;
            tx_next      = shreg[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_next = STOP;
          tx_next    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          // Chain straight into the next start bit when more bytes are queued.
          if (!empty) begin
            pop        = 1'b1;
            state_next = START;
            tx_next    = 1'b0;
          end else begin
            state_next = IDLE;
            tx_next    = 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
      end
    endcase
    if (pop) begin
      shreg_next   = mem[rd_ptr];
      bit_idx_next = 3'd0;
`ifdef UART_TX_PARITY_EN
      par_next     = ^mem[rd_ptr];
`endif
    end
  end

  always_ff @(posedge sck) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= 16'd0;
      bit_idx <= 3'd0;
      shreg   <= 8'd0;
      tx_q    <= 1'b1;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state   <= state_next;
      bit_cnt <= bit_cnt_next;
      bit_idx <= bit_idx_next;
      shreg   <= shreg_next;
      tx_q    <= tx_next;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_next;
`endif
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge sck) begin
    if (!rst && push) mem[wr_ptr] <= data_in;
  end

endmodule

// File: tb/tb_uart_tx_buf.sv
// Self-checking bench for uart_tx_buf: directed bit-level checks plus a serial
// line decoder that pops expected bytes from a scoreboard queue.
module tb_uart_tx_buf;

`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       sck;
  logic       rst;
  logic [7:0] data_in;
  logic       wr_en;
  logic       full;
  logic       empty;
  logic [2:0] level;
  logic       busy;
  logic       TX;
  logic [2:0] state_dbg;

  int compared   = 0;
  int mismatched = 0;
  logic [7:0] exp_q[$];

  uart_tx_buf #(.CLKS_PER_BIT(1), .DEPTH(4)) dut (
    .sck(sck), .rst(rst), .data_in(data_in), .wr_en(wr_en),
    .full(full), .empty(empty), .level(level), .busy(busy),
    .TX(TX), .state_dbg(state_dbg)
  );

  // clock / reset
  initial sck = 1'b0;
  always #5 sck = ~sck;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected line value for bit position i of one frame carrying byte b.
  function automatic logic frame_bit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
`ifdef UART_TX_PARITY_EN
    if (i == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // drivers
  task automatic step();
    @(posedge sck);
    #1;
  endtask

  task automatic drive_write(input logic [7:0] b, input logic accept);
    wr_en   = 1'b1;
    data_in = b;
    if (accept) exp_q.push_back(b);
  endtask

  // Called with TX already at frame bit 0; checks nfr contiguous frames then idle.
  task automatic expect_bits(input logic [7:0] b0, input logic [7:0] b1, input int nfr);
    for (int i = 0; i < nfr * NBITS; i++) begin
      check("tx_bit", 32'(TX), 32'(frame_bit((i < NBITS) ? b0 : b1, i % NBITS)));
      check("busy_in_frame", 32'(busy), 32'd1);
      step();
    end
    check("tx_after_frames", 32'(TX), 32'd1);
    check("busy_after_frames", 32'(busy), 32'd0);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!(empty && !busy) && n < budget) begin
      step();
      n++;
    end
    check("drain_within_budget", 32'(n < budget), 32'd1);
  endtask

  // scoreboard side: decode the serial line on the falling edge
  int         mon_pos = -1;
  logic [7:0] mon_byte;
  always @(negedge sck) begin
    if (rst) begin
      mon_pos = -1;
    end else if (mon_pos < 0) begin
      if (TX == 1'b0) mon_pos = 1;
    end else if (mon_pos <= 8) begin
      mon_byte = {TX, mon_byte[7:1]};
      mon_pos++;
`ifdef UART_TX_PARITY_EN
    end else if (mon_pos == 9) begin
      check("rx_parity", 32'(TX), 32'(^mon_byte));
      mon_pos++;
`endif
    end else begin
      check("rx_stop_bit", 32'(TX), 32'd1);
      if (exp_q.size() == 0) begin
        check("rx_unexpected_frame", 32'(mon_byte), 32'hFFFF_FFFF);
      end else begin
        check("rx_byte", 32'(mon_byte), 32'(exp_q.pop_front()));
      end
      mon_pos = -1;
    end
  end

  initial begin
    rst     = 1'b1;
    wr_en   = 1'b1;
    data_in = 8'h55;

    // reset held with wr_en high: nothing may be queued
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_tx", 32'(TX), 32'd1);
      check("rst_level", 32'(level), 32'd0);
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_full", 32'(full), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
    end
    rst   = 1'b0;
    wr_en = 1'b0;
    step();
    check("post_rst_level", 32'(level), 32'd0);
    check("post_rst_state", 32'(state_dbg), 32'd0);
    check("post_rst_tx", 32'(TX), 32'd1);

    // single bytes with exact line timing
    begin
      logic [7:0] singles [2];
      singles[0] = 8'h6B;
      singles[1] = 8'hA9;
      for (int s = 0; s < 2; s++) begin
        drive_write(singles[s], 1'b1);
        step();
        wr_en = 1'b0;
        check("write_level", 32'(level), 32'd1);
        check("write_tx_still_idle", 32'(TX), 32'd1);
        check("write_busy_low", 32'(busy), 32'd0);
        step();
        check("pop_level", 32'(level), 32'd0);
        expect_bits(singles[s], singles[s], 1);
        step();
      end
    end

    // back-to-back frames with no idle gap
    drive_write(8'h6B, 1'b1);
    step();
    drive_write(8'hA9, 1'b1);
    step();
    wr_en = 1'b0;
    check("push_pop_level", 32'(level), 32'd1);
    expect_bits(8'h6B, 8'hA9, 2);
    check("b2b_drained", 32'(exp_q.size()), 32'd0);

    // overflow while a frame is in flight
    step();
    drive_write(8'h6B, 1'b1);
    step();
    wr_en = 1'b0;
    step();
    check("ovf_busy", 32'(busy), 32'd1);
    for (int j = 1; j <= 5; j++) begin
      drive_write(8'(j), j <= 4);
      step();
      check("ovf_level", 32'(level), 32'((j < 4) ? j : 4));
      check("ovf_full", 32'(full), 32'(j >= 4));
    end
    wr_en = 1'b0;
    wait_idle(200);
    step();
    check("ovf_drained", 32'(exp_q.size()), 32'd0);

    // reset in the middle of data bit 3 with two bytes queued
    drive_write(8'h6B, 1'b1);
    step();
    drive_write(8'h11, 1'b1);
    step();
    drive_write(8'h22, 1'b1);
    step();
    wr_en = 1'b0;
    check("mid_queued_level", 32'(level), 32'd2);
    step();
    step();
    step();
    check("mid_bit3", 32'(TX), 32'(frame_bit(8'h6B, 4)));
    rst = 1'b1;
    exp_q.delete();
    step();
    rst = 1'b0;
    check("mid_rst_tx", 32'(TX), 32'd1);
    check("mid_rst_level", 32'(level), 32'd0);
    check("mid_rst_empty", 32'(empty), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    step();
    drive_write(8'hA9, 1'b1);
    step();
    wr_en = 1'b0;
    wait_idle(100);
    step();
    check("after_rst_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
